// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-access responder and the arbiter bench:
// FSM states, requester indices and default geometry.
package mem_ctrl_pkg;

  localparam int unsigned MEM_AW      = 4;
  localparam int unsigned MEM_DW      = 8;
  localparam int unsigned MEM_LATENCY = 2;

  localparam logic [1:0] REQ1 = 2'd0;
  localparam logic [1:0] REQ2 = 2'd1;
  localparam logic [1:0] REQ3 = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    RECOVER
  } state_e;

endpackage

// File: rtl/mem_access_responder_if.sv
// Grant/request bundle between the arbiter side (master) and the responder (slave).
interface mem_access_responder_if #(
  parameter int unsigned AW = mem_ctrl_pkg::MEM_AW,
  parameter int unsigned DW = mem_ctrl_pkg::MEM_DW
) ();

  logic          grant1, grant2, grant3;
  logic [AW-1:0] addr1, addr2, addr3;
  logic [DW-1:0] wdata1, wdata2, wdata3;
  logic          we1, we2, we3;
  logic [DW-1:0] rdata;
  logic          done1, done2, done3;
  logic          busy;
  logic          grant_err;

  modport slave (
    input  grant1, grant2, grant3, addr1, addr2, addr3,
           wdata1, wdata2, wdata3, we1, we2, we3,
    output rdata, done1, done2, done3, busy, grant_err
  );

  modport master (
    output grant1, grant2, grant3, addr1, addr2, addr3,
           wdata1, wdata2, wdata3, we1, we2, we3,
    input  rdata, done1, done2, done3, busy, grant_err
  );

endinterface

// File: rtl/mem_sp_ram.sv
// Single-port synchronous RAM, read-first, no reset on the array or read port.
module mem_sp_ram #(
  parameter int unsigned AW = mem_ctrl_pkg::MEM_AW,
  parameter int unsigned DW = mem_ctrl_pkg::MEM_DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/mem_access_responder.sv
// Serves the currently granted requester: captures its request, performs one
// RAM access after LATENCY cycles and returns a one-cycle done strobe.
module mem_access_responder
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned AW      = MEM_AW,
  parameter int unsigned DW      = MEM_DW,
  parameter int unsigned LATENCY = MEM_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_access_responder_if.slave bus
);

  localparam int unsigned   CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  state_e        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [2:0]    done_q, done_d;
  logic          busy_q, busy_d;
  logic          grant_err_q, grant_err_d;

  logic [2:0]    grant_vec_c;
  logic          grant_any_c;
  logic          capture_en_c;
  logic          access_c;
  logic [1:0]    sel_owner_c;
  logic [AW-1:0] sel_addr_c;
  logic [DW-1:0] sel_wdata_c;
  logic          sel_we_c;
  logic          ram_we_c;
  logic [AW-1:0] ram_addr_c;
  logic [DW-1:0] ram_rdata;

  assign grant_vec_c = {bus.grant3, bus.grant2, bus.grant1};
  assign grant_any_c = |grant_vec_c;
  // RECOVER's own cycle is the dead one; a grant standing at its closing edge
  // starts the next access, so back-to-back requests run every LATENCY+2 cycles.
  assign capture_en_c = (state_q == IDLE) || (state_q == RECOVER);
  assign access_c     = (state_q == WAIT) && (cnt_q == '0);

  // Fixed priority: requester 1 wins, so a non-one-hot vector picks the lowest index.
  always_comb begin
    sel_owner_c = REQ3;
    sel_addr_c  = bus.addr3;
    sel_wdata_c = bus.wdata3;
    sel_we_c    = bus.we3;
    if (bus.grant1) begin
      sel_owner_c = REQ1;
      sel_addr_c  = bus.addr1;
      sel_wdata_c = bus.wdata1;
      sel_we_c    = bus.we1;
    end else if (bus.grant2) begin
      sel_owner_c = REQ2;
      sel_addr_c  = bus.addr2;
      sel_wdata_c = bus.wdata2;
      sel_we_c    = bus.we2;
    end
  end

  // RAM reads every cycle; presenting the incoming address while capturing
  // makes the read word available by the access edge even with LATENCY=1.
  assign ram_we_c   = access_c && we_q && !reset;
  assign ram_addr_c = capture_en_c ? sel_addr_c : addr_q;

  mem_sp_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .addr  (ram_addr_c),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    done_d      = '0;
    busy_d      = busy_q;
    grant_err_d = 1'b0;
    case (state_q)
      IDLE, RECOVER: begin
        if (grant_any_c) begin
          state_d     = WAIT;
          owner_d     = sel_owner_c;
          addr_d      = sel_addr_c;
          wdata_d     = sel_wdata_c;
          we_d        = sel_we_c;
          cnt_d       = CNT_LOAD;
          busy_d      = 1'b1;
          grant_err_d = !$onehot(grant_vec_c);
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      WAIT: begin
        if (access_c) begin
          state_d = RESP;
          done_d  = 3'(3'b001 << owner_q);
          if (!we_q) rdata_d = ram_rdata;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = RECOVER;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= REQ1;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      grant_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      grant_err_q <= grant_err_d;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.done1     = done_q[0];
  assign bus.done2     = done_q[1];
  assign bus.done3     = done_q[2];
  assign bus.busy      = busy_q;
  assign bus.grant_err = grant_err_q;

endmodule

// File: tb/tb_mem_access_responder.sv
// Randomized self-checking bench: a LATENCY=2 responder against an array model
// of the memory, plus a LATENCY=1 instance for latency and throughput.
module tb_mem_access_responder;
  import mem_ctrl_pkg::*;

  localparam int L_A = 2;
  localparam int L_B = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_responder_if #(.AW(4), .DW(8)) ifa ();
  mem_access_responder_if #(.AW(4), .DW(8)) ifb ();

  mem_access_responder #(.AW(4), .DW(8), .LATENCY(L_A)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  mem_access_responder #(.AW(4), .DW(8), .LATENCY(L_B)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_mem [16];
  logic [7:0] model_rdata;

  // Observation record of the last observe_a() window, one bit per cycle k.
  int         done_mask [3];
  int         busy_mask;
  int         err_mask;
  logic [7:0] obs_rdata [16];
  logic [2:0] gq [$];

  function automatic int owner_of(input logic [2:0] g);
    if (g[0]) return 0;
    if (g[1]) return 1;
    return 2;
  endfunction

  task automatic set_req_a(input int idx, input logic [3:0] a, input logic [7:0] d, input logic w);
    case (idx)
      0:       begin ifa.addr1 = a; ifa.wdata1 = d; ifa.we1 = w; end
      1:       begin ifa.addr2 = a; ifa.wdata2 = d; ifa.we2 = w; end
      default: begin ifa.addr3 = a; ifa.wdata3 = d; ifa.we3 = w; end
    endcase
  endtask

  task automatic scramble_a();
    for (int i = 0; i < 3; i++) set_req_a(i, 4'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic clear_all();
    {ifa.grant3, ifa.grant2, ifa.grant1} = 3'b000;
    {ifb.grant3, ifb.grant2, ifb.grant1} = 3'b000;
    for (int i = 0; i < 3; i++) set_req_a(i, 4'h0, 8'h00, 1'b0);
    ifb.addr1 = '0; ifb.addr2 = '0; ifb.addr3 = '0;
    ifb.wdata1 = '0; ifb.wdata2 = '0; ifb.wdata3 = '0;
    ifb.we1 = 1'b0; ifb.we2 = 1'b0; ifb.we3 = 1'b0;
  endtask

  // Called at a negedge with the first grant vector already driven (capture edge = E0).
  // Cycle k lies between E0+k and E0+k+1; grants for the following edge come from gq[k].
  task automatic observe_a(input int ncyc, input bit scr);
    logic [2:0] g;
    done_mask = '{0, 0, 0};
    busy_mask = 0;
    err_mask  = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (ifa.done1 === 1'b1) done_mask[0] |= (1 << k);
      if (ifa.done2 === 1'b1) done_mask[1] |= (1 << k);
      if (ifa.done3 === 1'b1) done_mask[2] |= (1 << k);
      if (ifa.busy === 1'b1) busy_mask |= (1 << k);
      if (ifa.grant_err === 1'b1) err_mask |= (1 << k);
      obs_rdata[k] = ifa.rdata;
      g = (k < gq.size()) ? gq[k] : 3'b000;
      {ifa.grant3, ifa.grant2, ifa.grant1} = g;
      if (scr) scramble_a();
    end
  endtask

  task automatic test_reset();
    clear_all();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (ifa.rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata_a: got %h expected 00", ifa.rdata); end
    n_checks++; if ({ifa.done3, ifa.done2, ifa.done1} !== 3'b000) begin n_fail++; $display("FAIL reset_done_a: got %b expected 000", {ifa.done3, ifa.done2, ifa.done1}); end
    n_checks++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a: got %b expected 0", ifa.busy); end
    n_checks++; if (ifa.grant_err !== 1'b0) begin n_fail++; $display("FAIL reset_err_a: got %b expected 0", ifa.grant_err); end
    n_checks++; if (ifb.rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata_b: got %h expected 00", ifb.rdata); end
    n_checks++; if ({ifb.done3, ifb.done2, ifb.done1, ifb.busy, ifb.grant_err} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl_b: got %b expected 00000", {ifb.done3, ifb.done2, ifb.done1, ifb.busy, ifb.grant_err}); end
    reset = 1'b0;
    model_rdata = 8'h00;
  endtask

  task automatic test_write_then_read();
    int exp;
    // requester 3 writes A5 to address 5
    set_req_a(2, 4'h5, 8'hA5, 1'b1);
    {ifa.grant3, ifa.grant2, ifa.grant1} = 3'b100;
    gq = {};
    observe_a(6, 1'b1);
    model_mem[5] = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      exp = (i == 2) ? (1 << L_A) : 0;
      n_checks++; if (done_mask[i] !== exp) begin n_fail++; $display("FAIL wr_done%0d: got %h expected %h", i + 1, done_mask[i], exp); end
    end
    n_checks++; if (busy_mask !== ((1 << (L_A + 2)) - 1)) begin n_fail++; $display("FAIL wr_busy: got %h expected %h", busy_mask, (1 << (L_A + 2)) - 1); end
    n_checks++; if (obs_rdata[L_A] !== model_rdata || obs_rdata[5] !== model_rdata) begin n_fail++; $display("FAIL wr_rdata: got %h/%h expected %h", obs_rdata[L_A], obs_rdata[5], model_rdata); end
    // requester 2 reads address 5 back
    set_req_a(1, 4'h5, 8'($urandom), 1'b0);
    {ifa.grant3, ifa.grant2, ifa.grant1} = 3'b010;
    observe_a(6, 1'b1);
    n_checks++; if (done_mask[1] !== (1 << L_A) || done_mask[0] !== 0 || done_mask[2] !== 0) begin n_fail++; $display("FAIL rd_done: got %h/%h/%h expected 0/%h/0", done_mask[0], done_mask[1], done_mask[2], 1 << L_A); end
    n_checks++; if (obs_rdata[L_A - 1] !== model_rdata) begin n_fail++; $display("FAIL rd_early: got %h expected %h", obs_rdata[L_A - 1], model_rdata); end
    model_rdata = model_mem[5];
    n_checks++; if (obs_rdata[L_A] !== model_rdata) begin n_fail++; $display("FAIL rd_data: got %h expected %h", obs_rdata[L_A], model_rdata); end
    n_checks++; if (obs_rdata[5] !== model_rdata) begin n_fail++; $display("FAIL rd_hold: got %h expected %h", obs_rdata[5], model_rdata); end
  endtask

  task automatic test_fill();
    int o, exp;
    logic [7:0] d;
    for (int a = 0; a < 16; a++) begin
      o = $urandom_range(0, 2);
      d = (a == 9) ? 8'h5A : 8'($urandom);
      scramble_a();
      set_req_a(o, 4'(a), d, 1'b1);
      {ifa.grant3, ifa.grant2, ifa.grant1} = 3'(1 << o);
      observe_a(6, 1'b1);
      model_mem[a] = d;
      for (int i = 0; i < 3; i++) begin
        exp = (i == o) ? (1 << L_A) : 0;
        n_checks++; if (done_mask[i] !== exp) begin n_fail++; $display("FAIL fill_done%0d a=%0d: got %h expected %h", i + 1, a, done_mask[i], exp); end
      end
      n_checks++; if (busy_mask !== ((1 << (L_A + 2)) - 1)) begin n_fail++; $display("FAIL fill_busy a=%0d: got %h expected %h", a, busy_mask, (1 << (L_A + 2)) - 1); end
      n_checks++; if (obs_rdata[5] !== model_rdata) begin n_fail++; $display("FAIL fill_rdata a=%0d: got %h expected %h", a, obs_rdata[5], model_rdata); end
    end
  endtask

  task automatic test_random_mixed();
    int o;
    logic [3:0] a;
    logic [7:0] d;
    logic w;
    for (int n = 0; n < 24; n++) begin
      o = $urandom_range(0, 2);
      a = 4'($urandom);
      d = 8'($urandom);
      w = (a == 4'h9) ? 1'b0 : 1'($urandom);
      scramble_a();
      set_req_a(o, a, d, w);
      {ifa.grant3, ifa.grant2, ifa.grant1} = 3'(1 << o);
      observe_a(6, 1'b1);
      if (w) model_mem[a] = d;
      else   model_rdata = model_mem[a];
      n_checks++; if (done_mask[o] !== (1 << L_A) || err_mask !== 0) begin n_fail++; $display("FAIL mix_done n=%0d: got %h err %h expected %h err 0", n, done_mask[o], err_mask, 1 << L_A); end
      n_checks++; if (obs_rdata[L_A] !== model_rdata || obs_rdata[5] !== model_rdata) begin n_fail++; $display("FAIL mix_rdata n=%0d we=%b: got %h/%h expected %h", n, w, obs_rdata[L_A], obs_rdata[5], model_rdata); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [3:0] a;
    logic [7:0] d;
    a = 4'($urandom_range(0, 8));
    d = 8'($urandom);
    set_req_a(2, a, d, 1'b1);
    set_req_a(0, a, ~d, 1'b0);
    set_req_a(1, 4'hF, 8'h00, 1'b0);
    {ifa.grant3, ifa.grant2, ifa.grant1} = 3'b100;
    gq = {3'b000, 3'b001, 3'b001, 3'b001, 3'b000};
    observe_a(12, 1'b0);
    gq = {};
    model_mem[a] = d;
    model_rdata  = d;
    n_checks++; if (done_mask[2] !== (1 << L_A)) begin n_fail++; $display("FAIL busy_done3: got %h expected %h", done_mask[2], 1 << L_A); end
    n_checks++; if (done_mask[0] !== (1 << (2 * L_A + 2))) begin n_fail++; $display("FAIL busy_done1: got %h expected %h", done_mask[0], 1 << (2 * L_A + 2)); end
    n_checks++; if (done_mask[1] !== 0) begin n_fail++; $display("FAIL busy_done2: got %h expected 0", done_mask[1]); end
    n_checks++; if (busy_mask !== ((1 << (2 * L_A + 4)) - 1)) begin n_fail++; $display("FAIL busy_span: got %h expected %h", busy_mask, (1 << (2 * L_A + 4)) - 1); end
    n_checks++; if (obs_rdata[2 * L_A + 2] !== model_rdata) begin n_fail++; $display("FAIL busy_rdata: got %h expected %h", obs_rdata[2 * L_A + 2], model_rdata); end
  endtask

  task automatic test_grant_err();
    logic [2:0] gv [4];
    logic [3:0] a;
    logic [7:0] d;
    int o, o2, exp;
    gv = '{3'b110, 3'b111, 3'b011, 3'b101};
    for (int n = 0; n < 4; n++) begin
      o = owner_of(gv[n]);
      a = 4'($urandom_range(0, 8));
      d = 8'($urandom);
      for (int i = 0; i < 3; i++) set_req_a(i, a, ~d, 1'b1);
      set_req_a(o, a, d, 1'b1);
      {ifa.grant3, ifa.grant2, ifa.grant1} = gv[n];
      observe_a(6, 1'b1);
      model_mem[a] = d;
      n_checks++; if (err_mask !== 1) begin n_fail++; $display("FAIL err_pulse g=%b: got %h expected 1", gv[n], err_mask); end
      for (int i = 0; i < 3; i++) begin
        exp = (i == o) ? (1 << L_A) : 0;
        n_checks++; if (done_mask[i] !== exp) begin n_fail++; $display("FAIL err_done%0d g=%b: got %h expected %h", i + 1, gv[n], done_mask[i], exp); end
      end
      o2 = $urandom_range(0, 2);
      set_req_a(o2, a, 8'h00, 1'b0);
      {ifa.grant3, ifa.grant2, ifa.grant1} = 3'(1 << o2);
      observe_a(6, 1'b1);
      model_rdata = model_mem[a];
      n_checks++; if (obs_rdata[L_A] !== model_rdata || err_mask !== 0) begin n_fail++; $display("FAIL err_readback g=%b: got %h err %h expected %h err 0", gv[n], obs_rdata[L_A], err_mask, model_rdata); end
    end
  endtask

  task automatic test_reset_abort();
    set_req_a(0, 4'h9, 8'h3C, 1'b1);
    {ifa.grant3, ifa.grant2, ifa.grant1} = 3'b001;
    @(negedge clk);
    {ifa.grant3, ifa.grant2, ifa.grant1} = 3'b000;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", ifa.busy); end
    n_checks++; if ({ifa.done3, ifa.done2, ifa.done1} !== 3'b000) begin n_fail++; $display("FAIL abort_done_now: got %b expected 000", {ifa.done3, ifa.done2, ifa.done1}); end
    reset = 1'b0;
    model_rdata = 8'h00;
    observe_a(5, 1'b0);
    n_checks++; if ((done_mask[0] | done_mask[1] | done_mask[2] | busy_mask) !== 0) begin n_fail++; $display("FAIL abort_quiet: got done %h/%h/%h busy %h expected all 0", done_mask[0], done_mask[1], done_mask[2], busy_mask); end
    set_req_a(2, 4'h9, 8'h00, 1'b0);
    {ifa.grant3, ifa.grant2, ifa.grant1} = 3'b100;
    observe_a(6, 1'b1);
    n_checks++; if (obs_rdata[L_A - 1] !== 8'h00) begin n_fail++; $display("FAIL abort_rdata_cleared: got %h expected 00", obs_rdata[L_A - 1]); end
    model_rdata = model_mem[9];
    n_checks++; if (obs_rdata[L_A] !== model_rdata || done_mask[2] !== (1 << L_A)) begin n_fail++; $display("FAIL abort_old_value: got %h done %h expected %h done %h", obs_rdata[L_A], done_mask[2], model_rdata, 1 << L_A); end
  endtask

  task automatic test_latency1();
    int dm [3];
    int bm, exp_done, exp_busy;
    logic [7:0] d, r1, r_end;
    d = 8'($urandom);
    ifb.addr2 = 4'h3; ifb.wdata2 = d; ifb.we2 = 1'b1; ifb.grant2 = 1'b1;
    dm = '{0, 0, 0}; bm = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ifb.done1 === 1'b1) dm[0] |= (1 << k);
      if (ifb.done2 === 1'b1) dm[1] |= (1 << k);
      if (ifb.done3 === 1'b1) dm[2] |= (1 << k);
      if (ifb.busy === 1'b1) bm |= (1 << k);
      ifb.grant2 = 1'b0;
    end
    n_checks++; if (dm[1] !== (1 << L_B) || dm[0] !== 0 || dm[2] !== 0) begin n_fail++; $display("FAIL l1_write_done: got %h/%h/%h expected 0/%h/0", dm[0], dm[1], dm[2], 1 << L_B); end
    n_checks++; if (bm !== ((1 << (L_B + 2)) - 1)) begin n_fail++; $display("FAIL l1_write_busy: got %h expected %h", bm, (1 << (L_B + 2)) - 1); end
    // continuous grant1 reads: captures at edges 0, L+2, 2(L+2), ... while grant1 stands
    ifb.addr1 = 4'h3; ifb.we1 = 1'b0; ifb.wdata1 = 8'($urandom); ifb.grant1 = 1'b1;
    dm = '{0, 0, 0}; bm = 0; r1 = 8'h00; r_end = 8'h00;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (ifb.done1 === 1'b1) dm[0] |= (1 << k);
      if (ifb.done2 === 1'b1) dm[1] |= (1 << k);
      if (ifb.done3 === 1'b1) dm[2] |= (1 << k);
      if (ifb.busy === 1'b1) bm |= (1 << k);
      if (k == L_B) r1 = ifb.rdata;
      if (k == 13) r_end = ifb.rdata;
      if (k == 9) ifb.grant1 = 1'b0;
    end
    exp_done = 0; exp_busy = 0;
    for (int c = 0; c <= 9; c += L_B + 2) begin
      exp_done |= (1 << (c + L_B));
      for (int j = c; j <= c + L_B + 1; j++) exp_busy |= (1 << j);
    end
    n_checks++; if (dm[0] !== exp_done) begin n_fail++; $display("FAIL l1_done1_period: got %h expected %h", dm[0], exp_done); end
    n_checks++; if (dm[1] !== 0 || dm[2] !== 0) begin n_fail++; $display("FAIL l1_other_done: got %h/%h expected 0/0", dm[1], dm[2]); end
    n_checks++; if (bm !== exp_busy) begin n_fail++; $display("FAIL l1_busy: got %h expected %h", bm, exp_busy); end
    n_checks++; if (r1 !== d || r_end !== d) begin n_fail++; $display("FAIL l1_rdata: got %h/%h expected %h", r1, r_end, d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_then_read();
    test_fill();
    test_random_mixed();
    test_busy_ignore();
    test_grant_err();
    test_reset_abort();
    test_latency1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
